// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control unit sitting between instruction
// memory and the datapath. Fetches with a ready/valid stall, decodes a 4-bit
// opcode and sequences register file, ALU and data memory.
// Optional feature: define CONTROL_SEQ_BRANCH_EN to build Jmp/Jz (opcodes 6/7);
// without it those opcodes are treated as illegal.
module control_sequencer #(
    parameter int PC_W   = 7,
    parameter int RF_AW  = 4,
    parameter int D_AW   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_data,
    input  logic              rf_ra_zero,
    output logic [PC_W-1:0]   pc_addr,
    output logic              imem_rd,
    output logic [D_AW-1:0]   d_addr,
    output logic              d_rd,
    output logic              d_wr,
    output logic              rf_s,
    output logic              rf_w_en,
    output logic [RF_AW-1:0]  rf_w_addr,
    output logic [RF_AW-1:0]  rf_ra_addr,
    output logic [RF_AW-1:0]  rf_rb_addr,
    output logic              alu_s0,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        S_NOOP   = 4'd0,
        S_STORE  = 4'd1,
        S_LOAD_A = 4'd2,
        S_ADD    = 4'd3,
        S_SUB    = 4'd4,
        S_HALT   = 4'd5,
        S_LOAD_B = 4'd6,
        S_INIT   = 4'd7,
        S_FETCH  = 4'd8,
        S_DECODE = 4'd9
`ifdef CONTROL_SEQ_BRANCH_EN
        ,
        S_JMP    = 4'd10,
        S_JZ     = 4'd11
`endif
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic                illegal_q, illegal_d;

    // Instruction register fields
    logic [3:0]          op;
    logic [RF_AW-1:0]    ra, rb, rc;

    assign op = ir_q[INST_W-1 -: 4];
    assign ra = ir_q[INST_W-5 -: RF_AW];
    assign rb = ir_q[INST_W-5-RF_AW -: RF_AW];
    assign rc = ir_q[INST_W-5-2*RF_AW -: RF_AW];

`ifdef CONTROL_SEQ_BRANCH_EN
    logic [PC_W-1:0]     target;
    assign target = ir_q[PC_W-1:0];
`else
    // The zero flag only matters to Jz, which is not built here.
    logic                unused_ra_zero;
    assign unused_ra_zero = rf_ra_zero;
`endif

    // Address outputs track the IR fields in every state; only strobes are state-gated.
    assign pc_addr    = pc_q;
    assign d_addr     = ir_q[D_AW-1:0];
    assign rf_ra_addr = ra;
    assign rf_rb_addr = rb;
    assign illegal    = illegal_q;
    assign state_dbg  = state_q;

    // State, PC, IR and sticky illegal flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, register updates and Moore outputs per state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        imem_rd   = 1'b0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        rf_s      = 1'b0;
        rf_w_en   = 1'b0;
        rf_w_addr = rc;
        alu_s0    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                imem_rd = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    4'd0:    state_d = S_NOOP;
                    4'd1:    state_d = S_STORE;
                    4'd2:    state_d = S_LOAD_A;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
`ifdef CONTROL_SEQ_BRANCH_EN
                    4'd6:    state_d = S_JMP;
                    4'd7:    state_d = S_JZ;
`endif
                    default: begin
                        state_d   = S_NOOP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_STORE: begin
                d_wr    = 1'b1;
                state_d = S_FETCH;
            end
            S_LOAD_A: begin
                d_rd    = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                d_rd      = 1'b1;
                rf_s      = 1'b1;
                rf_w_en   = 1'b1;
                rf_w_addr = ra;
                state_d   = S_FETCH;
            end
            S_ADD: begin
                rf_w_en = 1'b1;
                state_d = S_FETCH;
            end
            S_SUB: begin
                rf_w_en = 1'b1;
                alu_s0  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
`ifdef CONTROL_SEQ_BRANCH_EN
            S_JMP: begin
                pc_d    = target;
                state_d = S_FETCH;
            end
            S_JZ: begin
                if (rf_ra_zero) pc_d = target;
                state_d = S_FETCH;
            end
`endif
            default:  state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: instruction-level reference model expanded
// into expected per-cycle output records, compared every cycle, plus directed
// literal checks. Random instruction stream with random fetch stalls and resets.
module tb_control_sequencer;
    localparam int PC_W = 7, RF_AW = 4, D_AW = 8, INST_W = 16;

    logic              clk = 1'b0;
    logic              reset, imem_valid, rf_ra_zero;
    logic [INST_W-1:0] imem_data;
    logic [PC_W-1:0]   pc_addr;
    logic              imem_rd, d_rd, d_wr, rf_s, rf_w_en, alu_s0, halted, illegal;
    logic [D_AW-1:0]   d_addr;
    logic [RF_AW-1:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [3:0]        state_dbg;

    always #5 clk = ~clk;

    control_sequencer #(.PC_W(PC_W), .RF_AW(RF_AW), .D_AW(D_AW), .INST_W(INST_W)) dut (
        .clk(clk), .reset(reset), .imem_valid(imem_valid), .imem_data(imem_data),
        .rf_ra_zero(rf_ra_zero), .pc_addr(pc_addr), .imem_rd(imem_rd), .d_addr(d_addr),
        .d_rd(d_rd), .d_wr(d_wr), .rf_s(rf_s), .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .alu_s0(alu_s0),
        .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
    );

    // One expected cycle of behaviour
    typedef struct {
        int st;
        bit imrd, rd, wr, s, wen, alu, hlt, use_ra, ill_set;
        int jmp;   // 0 none, 1 unconditional, 2 on zero flag
    } rec_t;

    rec_t            cur;
    rec_t            pend[$];
    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_ir;
    bit              m_ill;
    bit              chk_en = 0;
    int              vectors = 0, miscompares = 0;
    logic [15:0]     prog [0:127];

    function automatic rec_t mk(input int st);
        rec_t r;
        r.st = st; r.imrd = 0; r.rd = 0; r.wr = 0; r.s = 0; r.wen = 0;
        r.alu = 0; r.hlt = 0; r.use_ra = 0; r.ill_set = 0; r.jmp = 0;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_ill = 0;
        pend.delete();
        cur = mk(7);
    endtask

    // Expand one fetched instruction into its decode and execute cycles
    task automatic build(input logic [3:0] op);
        rec_t d, e, e2;
        d = mk(9);
        e = mk(0);
        e2 = mk(0);
        case (op)
            4'd0: begin pend.push_back(d); pend.push_back(mk(0)); end
            4'd1: begin e = mk(1); e.wr = 1; pend.push_back(d); pend.push_back(e); end
            4'd2: begin
                e = mk(2); e.rd = 1;
                e2 = mk(6); e2.rd = 1; e2.s = 1; e2.wen = 1; e2.use_ra = 1;
                pend.push_back(d); pend.push_back(e); pend.push_back(e2);
            end
            4'd3: begin e = mk(3); e.wen = 1; pend.push_back(d); pend.push_back(e); end
            4'd4: begin e = mk(4); e.wen = 1; e.alu = 1; pend.push_back(d); pend.push_back(e); end
            4'd5: begin e = mk(5); e.hlt = 1; pend.push_back(d); pend.push_back(e); end
`ifdef CONTROL_SEQ_BRANCH_EN
            4'd6: begin e = mk(10); e.jmp = 1; pend.push_back(d); pend.push_back(e); end
            4'd7: begin e = mk(11); e.jmp = 2; pend.push_back(d); pend.push_back(e); end
`endif
            default: begin d.ill_set = 1; pend.push_back(d); pend.push_back(mk(0)); end
        endcase
    endtask

    // Advance the model across one clock edge using the inputs present at that edge
    task automatic model_advance();
        rec_t f;
        if (reset) begin model_reset(); return; end
        if (cur.ill_set) m_ill = 1;
        if (cur.jmp == 1 || (cur.jmp == 2 && rf_ra_zero)) m_pc = m_ir[PC_W-1:0];
        if (cur.hlt) return;
        if (cur.imrd) begin
            if (!imem_valid) return;
            m_ir = imem_data;
            m_pc = m_pc + 7'd1;
            build(imem_data[15:12]);
        end
        if (pend.size() > 0) cur = pend.pop_front();
        else begin f = mk(8); f.imrd = 1; cur = f; end
    endtask

    task automatic compare();
        logic [38:0] got, exp;
        logic [3:0]  wa;
        wa  = cur.use_ra ? m_ir[11:8] : m_ir[3:0];
        exp = {4'(cur.st), m_pc, cur.imrd, m_ir[7:0], cur.rd, cur.wr, cur.s, cur.wen,
               wa, m_ir[11:8], m_ir[7:4], cur.alu, cur.hlt, m_ill};
        got = {state_dbg, pc_addr, imem_rd, d_addr, d_rd, d_wr, rf_s, rf_w_en,
               rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s0, halted, illegal};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle t=%0t outputs got %h expected %h", $time, got, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance model after the edge
    task automatic cyc(input bit r, input bit v, input logic [15:0] d, input bit z);
        reset = r; imem_valid = v; imem_data = d; rf_ra_zero = z;
        @(negedge clk);
        if (chk_en) compare();
        @(posedge clk);
        #2;
        model_advance();
    endtask

    task automatic c(input bit v, input logic [15:0] d);
        cyc(0, v, d, 0);
    endtask

    initial begin
        int exp_seq [10];
        int hcnt;
        bit r, v, z;
        logic [3:0] op;
        logic [15:0] d;
        int p;

        for (int i = 0; i < 128; i++) prog[i] = 16'h0000;
        prog[0] = 16'h2110;   // Load R1 <- [0x10]
        prog[1] = 16'h3123;   // Add  R3 = R1 + R2
        prog[2] = 16'h1320;   // Store R3 -> [0x20]
        exp_seq = '{9, 2, 6, 8, 9, 3, 8, 9, 1, 8};

        model_reset();
        cyc(1, 0, 16'h0, 0);
        cyc(1, 0, 16'h0, 0);
        chk_en = 1;

        // Reset state and Noop walk
        lit("rst_state", 32'(state_dbg), 7);
        lit("rst_pc", 32'(pc_addr), 0);
        lit("rst_illegal", 32'(illegal), 0);
        lit("rst_strobes", {28'd0, imem_rd, d_rd, d_wr, rf_w_en}, 0);
        c(1, 16'h0000); lit("noop_s1", 32'(state_dbg), 8);
        c(1, 16'h0000); lit("noop_s2", 32'(state_dbg), 9); lit("noop_pc", 32'(pc_addr), 1);
        c(1, 16'h0000); lit("noop_s3", 32'(state_dbg), 0);
        c(1, 16'h0000); lit("noop_s4", 32'(state_dbg), 8);
        lit("noop_illegal", 32'(illegal), 0);

        // Load / Add / Store program, 10 cycles
        cyc(1, 0, 16'h0, 0);
        c(1, 16'h0);
        for (int i = 0; i < 10; i++) begin
            c(1, prog[m_pc]);
            lit("prog_state", 32'(state_dbg), 32'(exp_seq[i]));
            if (i == 1) begin
                lit("loadA_rd", 32'(d_rd), 1); lit("loadA_addr", 32'(d_addr), 32'h10);
            end
            if (i == 2) begin
                lit("loadB_rd", 32'(d_rd), 1); lit("loadB_wen", 32'(rf_w_en), 1);
                lit("loadB_waddr", 32'(rf_w_addr), 1); lit("loadB_s", 32'(rf_s), 1);
            end
            if (i == 5) begin
                lit("add_wen", 32'(rf_w_en), 1); lit("add_waddr", 32'(rf_w_addr), 3);
                lit("add_alu", 32'(alu_s0), 0);
            end
            if (i == 8) begin
                lit("store_wr", 32'(d_wr), 1); lit("store_addr", 32'(d_addr), 32'h20);
            end
        end

        // Fetch wait-states
        for (int i = 0; i < 3; i++) begin
            c(0, 16'hFFFF);
            lit("stall_state", 32'(state_dbg), 8);
            lit("stall_rd", 32'(imem_rd), 1);
            lit("stall_pc", 32'(pc_addr), 3);
        end
        c(1, 16'h3456);
        lit("stall_dec", 32'(state_dbg), 9); lit("stall_pc1", 32'(pc_addr), 4);
        lit("stall_ra", 32'(rf_ra_addr), 4); lit("stall_rb", 32'(rf_rb_addr), 5);
        c(1, 16'h0); lit("stall_wa", 32'(rf_w_addr), 6);
        c(1, 16'h0);

        // Illegal opcode, sticky until reset
        cyc(1, 0, 16'h0, 0); c(1, 16'h0);
        c(1, 16'hF000); lit("ill_dec", 32'(illegal), 0);
        c(1, 16'h0);    lit("ill_noop", 32'(state_dbg), 0); lit("ill_set", 32'(illegal), 1);
        c(1, 16'h0); c(1, 16'h3123); c(1, 16'h0);
        lit("ill_add", 32'(state_dbg), 3); lit("ill_sticky", 32'(illegal), 1);
        cyc(1, 0, 16'h0, 0); lit("ill_clr", 32'(illegal), 0);

        // Branches
        c(1, 16'h0);
`ifdef CONTROL_SEQ_BRANCH_EN
        c(1, 16'h7005); c(1, 16'h0); lit("jz_state", 32'(state_dbg), 11);
        cyc(0, 1, 16'h0, 1); lit("jz_taken", 32'(pc_addr), 5);
        c(1, 16'h7005); c(1, 16'h0);
        cyc(0, 1, 16'h0, 0); lit("jz_not", 32'(pc_addr), 6);
        c(1, 16'h607F); c(1, 16'h0); lit("jmp_state", 32'(state_dbg), 10);
        c(1, 16'h0);    lit("jmp_7f", 32'(pc_addr), 32'h7F);
        c(1, 16'h6010); lit("pc_wrap", 32'(pc_addr), 0);
        c(1, 16'h0); c(1, 16'h0); lit("jmp_10", 32'(pc_addr), 32'h10);
`else
        c(1, 16'h6010); c(1, 16'h0);
        lit("op6_noop", 32'(state_dbg), 0); lit("op6_ill", 32'(illegal), 1);
        c(1, 16'h0);
`endif

        // Halt for 20 cycles, then reset during Load_A
        cyc(1, 0, 16'h0, 0); c(1, 16'h0);
        c(1, 16'h5000); c(1, 16'h0);
        for (int i = 0; i < 20; i++) begin
            c(1, 16'h0);
            lit("halt_flag", 32'(halted), 1);
            lit("halt_nord", 32'(imem_rd), 0);
        end
        cyc(1, 0, 16'h0, 0); c(1, 16'h0);
        c(1, 16'h2110); c(1, 16'h0);
        lit("loadA_pre", 32'(state_dbg), 2);
        cyc(1, 1, 16'h0, 0);
        lit("rst_mid_state", 32'(state_dbg), 7); lit("rst_mid_rd", 32'(d_rd), 0);
        lit("rst_mid_pc", 32'(pc_addr), 0);

        // Randomized stream
        hcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            hcnt = cur.hlt ? hcnt + 1 : 0;
            r = ($urandom_range(0, 249) == 0) || (hcnt > 25);
            v = ($urandom_range(0, 3) != 0);
            z = $urandom_range(0, 1) == 1;
            p = $urandom_range(0, 99);
            if (p < 4)      op = 4'($urandom_range(8, 15));
            else if (p < 9) op = 4'd5;
            else            op = 4'($urandom_range(0, 7));
            d = {op, 12'($urandom)};
            cyc(r, v, d, z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
